shifter_pipe: RTL

Pipelined, parametrised barrel shifter for the FP ALU datapath. It generalises the combinational mantissa shifter in several ways: configurable width, a valid/ready handshake, arithmetic and normalise modes, and sticky/overflow flags for rounding. It sits between exponent compare and the add/round stages. It serves both alignment right-shifts and post-add normalisation left-shifts.

---
 rtl/shifter_pipe.sv | 134 +++++++++++++
 1 files changed

// File: rtl/shifter_pipe.sv
// shifter_pipe: two-stage barrel shifter for the FP ALU datapath.
// Stage 1 does the coarse shift (or leading-zero count); stage 2 the fine shift and flags.
module shifter_pipe #(
  parameter  int WIDTH = 24,
  parameter  int BYW   = 8,
  localparam int LZW   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  input  logic [BYW-1:0]   by,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_sticky,
  output logic             out_ovf,
  output logic [LZW-1:0]   out_lzc
);

  localparam int FB = 2;
  localparam int AW = (BYW > LZW) ? BYW : LZW;
  localparam int W2 = 2 * WIDTH;

  logic                    adv;
  logic                    norm, arith, go_left, go_right, sat;
  logic [BYW-1:0]          mag;
  logic [LZW-1:0]          lzc;
  logic [AW-1:0]           amt, coarse;
  logic [W2-1:0]           ext_l, ext_r;
  logic signed [W2-1:0]    ext_a;
  logic [WIDTH-1:0]        s1_data_d;
  logic                    s1_flag_d;
  logic [FB-1:0]           s1_fine_d;

  logic                    s1_v, s1_flag, s1_left, s1_right, s1_fill;
  logic [WIDTH-1:0]        s1_data;
  logic [FB-1:0]           s1_fine;
  logic [LZW-1:0]          s1_lzc;

  logic [W2-1:0]           e2_l, e2_r;
  logic signed [W2-1:0]    e2_a;
  logic [WIDTH-1:0]        out_d;
  logic                    flag_d;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage 1: magnitude, LZC, coarse shift on the upper bits of the amount
  always_comb begin
    norm     = (mode == 2'b10);
    arith    = (mode == 2'b01);
    mag      = by[BYW-1] ? -by : by;
    lzc      = LZW'(WIDTH);
    for (int i = 0; i < WIDTH; i++)
      if (in[i]) lzc = LZW'(WIDTH - 1 - i);
    amt      = norm ? AW'(lzc) : AW'(mag);
    go_left  = norm | (!by[BYW-1] & (|by));
    go_right = !norm & by[BYW-1];
    sat      = (amt >= AW'(WIDTH));
    coarse   = amt & ~AW'((1 << FB) - 1);
    ext_l    = {{WIDTH{1'b0}}, in} << coarse;
    ext_r    = {in, {WIDTH{1'b0}}} >> coarse;
    ext_a    = $signed({in, {WIDTH{1'b0}}}) >>> coarse;

    s1_data_d = in;
    s1_flag_d = 1'b0;
    s1_fine_d = '0;
    if (sat && (go_left || go_right)) begin
      // whole operand leaves the word; only the sign fill can survive
      s1_data_d = {WIDTH{go_right & arith & in[WIDTH-1]}};
      s1_flag_d = !norm & (|in);
    end else if (go_left) begin
      s1_data_d = ext_l[WIDTH-1:0];
      s1_flag_d = |ext_l[W2-1:WIDTH];
      s1_fine_d = amt[FB-1:0];
    end else if (go_right) begin
      s1_data_d = arith ? ext_a[W2-1:WIDTH] : ext_r[W2-1:WIDTH];
      s1_flag_d = arith ? (|ext_a[WIDTH-1:0]) : (|ext_r[WIDTH-1:0]);
      s1_fine_d = amt[FB-1:0];
    end
  end

  // Stage 2: fine shift, flags accumulate across both stages
  always_comb begin
    e2_l   = {{WIDTH{1'b0}}, s1_data} << s1_fine;
    e2_r   = {s1_data, {WIDTH{1'b0}}} >> s1_fine;
    e2_a   = $signed({s1_data, {WIDTH{1'b0}}}) >>> s1_fine;
    out_d  = s1_data;
    flag_d = s1_flag;
    if (s1_left) begin
      out_d  = e2_l[WIDTH-1:0];
      flag_d = s1_flag | (|e2_l[W2-1:WIDTH]);
    end else if (s1_right) begin
      out_d  = s1_fill ? e2_a[W2-1:WIDTH] : e2_r[W2-1:WIDTH];
      flag_d = s1_flag | (s1_fill ? (|e2_a[WIDTH-1:0]) : (|e2_r[WIDTH-1:0]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v       <= 1'b0;
      s1_data    <= '0;
      s1_flag    <= 1'b0;
      s1_fine    <= '0;
      s1_left    <= 1'b0;
      s1_right   <= 1'b0;
      s1_fill    <= 1'b0;
      s1_lzc     <= '0;
      out_valid  <= 1'b0;
      out        <= '0;
      out_sticky <= 1'b0;
      out_ovf    <= 1'b0;
      out_lzc    <= '0;
    end else if (adv) begin
      s1_v       <= in_valid;
      s1_data    <= s1_data_d;
      s1_flag    <= s1_flag_d;
      s1_fine    <= s1_fine_d;
      s1_left    <= go_left;
      s1_right   <= go_right;
      s1_fill    <= go_right & arith & in[WIDTH-1];
      s1_lzc     <= norm ? lzc : '0;
      out_valid  <= s1_v;
      out        <= out_d;
      out_sticky <= s1_right & flag_d;
      out_ovf    <= s1_left & flag_d;
      out_lzc    <= s1_lzc;
    end
  end

endmodule
